p4_memwb_skid: RTL



---
 rtl/p4_memwb_skid.sv | 80 ++++++++
 1 files changed

// File: rtl/p4_memwb_skid.sv
// p4_memwb_skid: MEM/WB stage with valid/ready handshake and a 2-entry skid buffer (registered in_ready).
// Optional P4_MEMWB_X0_SQUASH_EN: entries writing x0 are stored with INVALID_TYPE.
module p4_memwb_skid #(
    parameter int          DATA_W       = 32,
    parameter int          RD_W         = 5,
    parameter int          TYPE_W       = 3,
    parameter int unsigned INVALID_TYPE = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TYPE_W-1:0] in_type,
    input  logic [DATA_W-1:0] in_data,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TYPE_W-1:0] out_type,
    output logic [DATA_W-1:0] out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic [1:0]        occupancy
);
    localparam logic [TYPE_W-1:0] INV_T = TYPE_W'(INVALID_TYPE);
    logic              h_valid = 1'b0;
    logic              s_valid = 1'b0;
    logic [TYPE_W-1:0] h_type, s_type, store_type;
    logic [DATA_W-1:0] h_data, s_data;
    logic [RD_W-1:0]   h_rd, s_rd;
    logic              accept, consume, h_free;
    assign accept  = in_valid & ~s_valid;
    assign consume = h_valid & out_ready;
    assign h_free  = ~h_valid | consume;
`ifdef P4_MEMWB_X0_SQUASH_EN
    assign store_type = (in_rd == '0) ? INV_T : in_type;
`else
    assign store_type = in_type;
`endif
    // S only fills while H is held, so in_ready is simply the registered S-empty bit
    always_ff @(posedge clock) begin
        if (reset) begin
            h_valid <= 1'b0;
            s_valid <= 1'b0;
            h_type  <= '0;
            h_data  <= '0;
            h_rd    <= '0;
            s_type  <= '0;
            s_data  <= '0;
            s_rd    <= '0;
        end else if (flush) begin
            h_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (h_free) begin
            if (s_valid) begin
                h_type  <= s_type;
                h_data  <= s_data;
                h_rd    <= s_rd;
                s_valid <= 1'b0;
            end else begin
                h_valid <= accept;
                if (accept) begin
                    h_type <= store_type;
                    h_data <= in_data;
                    h_rd   <= in_rd;
                end
            end
        end else if (accept) begin
            s_type  <= store_type;
            s_data  <= in_data;
            s_rd    <= in_rd;
            s_valid <= 1'b1;
        end
    end
    assign in_ready  = ~s_valid;
    assign out_valid = h_valid;
    assign out_type  = h_valid ? h_type : INV_T;
    assign out_data  = h_data;
    assign out_rd    = h_rd;
    assign occupancy = {1'b0, h_valid} + {1'b0, s_valid};
endmodule
